xcorr_engine: RTL

Parametrised sequential cross-correlation / convolution engine for signed sample vectors. It holds two LEN-sample buffers (A, B) loaded over a simple write port, computes all 2·LEN−1 output lags with one multiply-accumulate per cycle, and streams the results out over a valid/ready interface. It sits between the sample capture logic and the peak-detect / result-reporting stage.

---
 rtl/xcorr_engine.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/xcorr_engine.sv
// Sequential cross-correlation / convolution engine: one signed MAC per cycle over two LEN-sample buffers.
// Define XCORR_SATURATE_EN to clamp results to OUT_W; otherwise results wrap to the low OUT_W bits.
module xcorr_engine #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned LEN    = 2000,
   parameter int unsigned ACC_W  = 2 * DATA_W + $clog2(LEN),
   parameter int unsigned OUT_W  = 2 * DATA_W
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic                           ld_valid,
   input  logic                           ld_sel,
   input  logic [$clog2(LEN)-1:0]         ld_addr,
   input  logic [DATA_W-1:0]              ld_data,
   input  logic                           start,
   input  logic                           mode,
   output logic                           busy,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [OUT_W-1:0]               out_data,
   output logic [$clog2(2*LEN-1)-1:0]     out_index,
   output logic                           out_last,
   output logic                           done
);
   localparam int unsigned AW    = $clog2(LEN);
   localparam int unsigned NW    = $clog2(2 * LEN - 1);
   localparam int unsigned CW    = $clog2(LEN + 1);
   localparam int unsigned PW    = 2 * DATA_W;
   localparam int unsigned LAST  = 2 * LEN - 2;

   typedef enum logic [1:0] {IDLE, CALC, EMIT} state_t;

   state_t                   state, state_next;
   logic signed [DATA_W-1:0] buf_a [LEN];
   logic signed [DATA_W-1:0] buf_b [LEN];
   logic                     mode_q;
   logic [NW-1:0]            n_q;
   logic [CW-1:0]            cnt_q;
   logic [AW-1:0]            i_q, j_q;
   logic signed [ACC_W-1:0]  acc_q;

   logic                     begin_run, last_term, next_lag, finish;
   logic [NW-1:0]            n_setup;
   logic                     mode_setup;
   logic [AW-1:0]            i_setup, j_setup;
   logic [CW-1:0]            t_setup;
   logic signed [PW-1:0]     prod;
   logic signed [ACC_W-1:0]  acc_sum;
   logic [OUT_W-1:0]         result;

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_next;
   end

   // Next-state and control decode
   always_comb begin
      state_next = state;
      begin_run  = 1'b0;
      last_term  = 1'b0;
      next_lag   = 1'b0;
      finish     = 1'b0;
      case (state)
         IDLE: if (start) begin
            begin_run  = 1'b1;
            state_next = CALC;
         end
         CALC: if (cnt_q == CW'(1)) begin
            last_term  = 1'b1;
            state_next = EMIT;
         end
         EMIT: if (out_ready) begin
            if (n_q == NW'(LAST)) begin
               finish     = 1'b1;
               state_next = IDLE;
            end else begin
               next_lag   = 1'b1;
               state_next = CALC;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Starting indices and term count for the lag about to be computed
   always_comb begin
      n_setup    = begin_run ? '0 : n_q + NW'(1);
      mode_setup = begin_run ? mode : mode_q;
      if (32'(n_setup) >= LEN - 1) begin
         i_setup = AW'(32'(n_setup) - (LEN - 1));
         j_setup = mode_setup ? AW'(LEN - 1) : '0;
         t_setup = CW'(2 * LEN - 1 - 32'(n_setup));
      end else begin
         i_setup = '0;
         j_setup = mode_setup ? AW'(n_setup) : AW'(LEN - 1 - 32'(n_setup));
         t_setup = CW'(32'(n_setup) + 1);
      end
   end

   // Full-precision product, sign-extended into the accumulator
   always_comb begin
      prod    = PW'(buf_a[i_q]) * PW'(buf_b[j_q]);
      acc_sum = acc_q + ACC_W'(prod);
`ifdef XCORR_SATURATE_EN
      if ((&acc_sum[ACC_W-1:OUT_W-1]) || !(|acc_sum[ACC_W-1:OUT_W-1]))
         result = acc_sum[OUT_W-1:0];
      else if (acc_sum[ACC_W-1])
         result = {1'b1, {(OUT_W-1){1'b0}}};
      else
         result = {1'b0, {(OUT_W-1){1'b1}}};
`else
      result = acc_sum[OUT_W-1:0];
`endif
   end

   // Sample buffers; writable only while idle
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < LEN; k++) begin
            buf_a[k] <= '0;
            buf_b[k] <= '0;
         end
      end else if (state == IDLE && ld_valid && 32'(ld_addr) < LEN) begin
         if (ld_sel) buf_b[ld_addr] <= ld_data;
         else        buf_a[ld_addr] <= ld_data;
      end
   end

   // MAC datapath and registered outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mode_q    <= 1'b0;
         n_q       <= '0;
         cnt_q     <= '0;
         i_q       <= '0;
         j_q       <= '0;
         acc_q     <= '0;
         busy      <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_index <= '0;
         out_last  <= 1'b0;
         done      <= 1'b0;
      end else begin
         if (begin_run || next_lag) begin
            n_q    <= n_setup;
            mode_q <= mode_setup;
            i_q    <= i_setup;
            j_q    <= j_setup;
            cnt_q  <= t_setup;
            acc_q  <= '0;
         end else if (state == CALC) begin
            acc_q <= acc_sum;
            i_q   <= i_q + AW'(1);
            j_q   <= mode_q ? j_q - AW'(1) : j_q + AW'(1);
            cnt_q <= cnt_q - CW'(1);
            if (last_term) begin
               out_data  <= result;
               out_index <= n_q;
               out_last  <= (n_q == NW'(LAST));
            end
         end
         busy      <= (state_next != IDLE);
         out_valid <= (state_next == EMIT);
         done      <= finish;
      end
   end
endmodule
